// File: rtl/dmem_ctrl_pkg.sv
// dmem_ctrl_pkg -- shared types for the data-memory port controller.
//   dmem_state_t : controller FSM states (IDLE, BUSY, DONE)
//   dmem_req_t   : request held toward the data cache while an access is in flight
// The struct fields use the package widths. The controller's ADDR_W/DATA_W
// parameters default to these widths and must be kept equal to them.
package dmem_ctrl_pkg;

    localparam int DMEM_ADDR_W = 32;
    localparam int DMEM_DATA_W = 32;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } dmem_state_t;

    typedef struct packed {
        logic                     op_write;
        logic [DMEM_ADDR_W-1:0]   addr;
        logic [DMEM_DATA_W/8-1:0] mbe;
        logic [DMEM_DATA_W-1:0]   wdata;
    } dmem_req_t;

endpackage

// File: rtl/dmem_ctrl_sat_counter.sv
// sat_counter -- saturating up-counter used for the dmem performance counters.
//   clk   : clock
//   rst   : synchronous active-low reset, clears count
//   inc   : add one this cycle (ignored once count is all-ones)
//   count : current value, sticks at all-ones
module sat_counter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    output logic [W-1:0] count
);

    always_ff @(posedge clk) begin
        if (!rst) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + W'(1);
        end
    end

endmodule

// File: rtl/dmem_ctrl.sv
// dmem_ctrl -- data-memory port controller between the MEM stage and the data cache.
// Converts MEM's per-cycle request into a request held until the cache responds,
// stalls the pipeline meanwhile, and returns captured read data to MEM.
// A completed access is never re-issued while the pipeline stays frozen (DONE).
// Ports:
//   clk, rst                         clock, synchronous active-low reset
//   req_read/req_write/req_addr/
//   req_mbe/req_wdata                MEM-stage request (sampled in IDLE only)
//   pipe_en                          whole pipeline advances this cycle
//   dmem_read/dmem_write/dmem_address/
//   dmem_byte_enable/dmem_wdata      registered cache request
//   dmem_rdata, dmem_resp            cache read data and one-cycle completion
//   rdata_out                        captured read data to MEM
//   stall                            controller busy
//   perf_loads/perf_stores/
//   perf_stall_cyc                   performance counters
// Build option: define DMEM_PERF_EN to get saturating performance counters;
// otherwise the perf_* ports are tied to zero and no counter flops exist.
module dmem_ctrl
    import dmem_ctrl_pkg::*;
#(
    parameter int ADDR_W = DMEM_ADDR_W,
    parameter int DATA_W = DMEM_DATA_W,
    parameter int PERF_W = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                req_read,
    input  logic                req_write,
    input  logic [ADDR_W-1:0]   req_addr,
    input  logic [DATA_W/8-1:0] req_mbe,
    input  logic [DATA_W-1:0]   req_wdata,
    input  logic                pipe_en,
    output logic                dmem_read,
    output logic                dmem_write,
    output logic [ADDR_W-1:0]   dmem_address,
    output logic [DATA_W/8-1:0] dmem_byte_enable,
    output logic [DATA_W-1:0]   dmem_wdata,
    input  logic [DATA_W-1:0]   dmem_rdata,
    input  logic                dmem_resp,
    output logic [DATA_W-1:0]   rdata_out,
    output logic                stall,
    output logic [PERF_W-1:0]   perf_loads,
    output logic [PERF_W-1:0]   perf_stores,
    output logic [PERF_W-1:0]   perf_stall_cyc
);

    dmem_state_t       state;
    dmem_req_t         req_q;
    logic [DATA_W-1:0] rdata_q;
    logic              rd_q;
    logic              wr_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            // Dropping the request here abandons any in-flight access.
            state   <= IDLE;
            req_q   <= '0;
            rd_q    <= 1'b0;
            wr_q    <= 1'b0;
            rdata_q <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_read || req_write) begin
                        // Simultaneous read+write is resolved as a write.
                        req_q <= '{op_write: req_write,
                                   addr:     req_addr,
                                   mbe:      req_mbe,
                                   wdata:    req_wdata};
                        rd_q  <= ~req_write;
                        wr_q  <= req_write;
                        state <= BUSY;
                    end
                end
                BUSY: begin
                    if (dmem_resp) begin
                        if (!req_q.op_write) rdata_q <= dmem_rdata;
                        rd_q  <= 1'b0;
                        wr_q  <= 1'b0;
                        state <= DONE;
                    end
                end
                DONE: begin
                    // Wait for the pipeline to move on; otherwise the same
                    // instruction would still be in MEM and get re-issued.
                    if (pipe_en) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Stall starts combinationally in the cycle MEM presents the request so
    // the pipeline never advances past an access that has not been issued.
    always_comb begin
        stall = 1'b0;
        case (state)
            IDLE:    stall = req_read | req_write;
            BUSY:    stall = 1'b1;
            default: stall = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst && (state == IDLE)) begin
            assert (!(req_read && req_write));
        end
    end

    assign dmem_read        = rd_q;
    assign dmem_write       = wr_q;
    assign dmem_address     = req_q.addr;
    assign dmem_byte_enable = req_q.mbe;
    assign dmem_wdata       = req_q.wdata;
    assign rdata_out        = rdata_q;

`ifdef DMEM_PERF_EN
    logic done_evt;
    assign done_evt = (state == BUSY) && dmem_resp;

    sat_counter #(.W(PERF_W)) u_cnt_loads (
        .clk   (clk),
        .rst   (rst),
        .inc   (done_evt && !req_q.op_write),
        .count (perf_loads)
    );

    sat_counter #(.W(PERF_W)) u_cnt_stores (
        .clk   (clk),
        .rst   (rst),
        .inc   (done_evt && req_q.op_write),
        .count (perf_stores)
    );

    sat_counter #(.W(PERF_W)) u_cnt_stall (
        .clk   (clk),
        .rst   (rst),
        .inc   (stall),
        .count (perf_stall_cyc)
    );
`else
    assign perf_loads     = '0;
    assign perf_stores    = '0;
    assign perf_stall_cyc = '0;
`endif

endmodule

// File: tb/tb_dmem_ctrl.sv
// tb_dmem_ctrl -- directed self-checking bench for dmem_ctrl.
// Issued cache requests are checked against a scoreboard of the requests the
// bench drove; the linear sequence checks stall, latency and read data.
module tb_dmem_ctrl;
    import dmem_ctrl_pkg::*;

`ifdef DMEM_PERF_EN
    localparam int PW = 4;
`else
    localparam int PW = 32;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic          req_read, req_write, pipe_en, dmem_resp;
    logic [31:0]   req_addr, req_wdata, dmem_rdata;
    logic [3:0]    req_mbe;
    logic          dmem_read, dmem_write, stall;
    logic [31:0]   dmem_address, dmem_wdata, rdata_out;
    logic [3:0]    dmem_byte_enable;
    logic [PW-1:0] perf_loads, perf_stores, perf_stall_cyc;

    int errors = 0;
    int checks = 0;

    dmem_req_t   sb[$];
    dmem_req_t   cur;
    logic        prev_act = 1'b0;
    logic [31:0] model_rdata = '0;

    always #5 clk = ~clk;

    dmem_ctrl #(.ADDR_W(32), .DATA_W(32), .PERF_W(PW)) dut (
        .clk(clk), .rst(rst),
        .req_read(req_read), .req_write(req_write), .req_addr(req_addr),
        .req_mbe(req_mbe), .req_wdata(req_wdata), .pipe_en(pipe_en),
        .dmem_read(dmem_read), .dmem_write(dmem_write), .dmem_address(dmem_address),
        .dmem_byte_enable(dmem_byte_enable), .dmem_wdata(dmem_wdata),
        .dmem_rdata(dmem_rdata), .dmem_resp(dmem_resp), .rdata_out(rdata_out),
        .stall(stall), .perf_loads(perf_loads), .perf_stores(perf_stores),
        .perf_stall_cyc(perf_stall_cyc)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Issued requests must match the scoreboard and stay constant while held.
    always @(negedge clk) begin
        if (dmem_read || dmem_write) begin
            if (!prev_act) begin
                chk("issue_expected", 64'(sb.size() != 0), 64'd1);
                if (sb.size() != 0) cur = sb.pop_front();
            end
            chk("req_write", 64'(dmem_write), 64'(cur.op_write));
            chk("req_read", 64'(dmem_read), 64'(!cur.op_write));
            chk("req_addr", 64'(dmem_address), 64'(cur.addr));
            chk("req_mbe", 64'(dmem_byte_enable), 64'(cur.mbe));
            chk("req_wdata", 64'(dmem_wdata), 64'(cur.wdata));
        end
        prev_act = dmem_read || dmem_write;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One full access: request in cycle 0, dmem_* held for n cycles with the
    // response in the last of them, then one cycle in DONE (request held).
    task automatic access(input bit wr, input logic [31:0] a, input logic [3:0] m,
                          input logic [31:0] wd, input logic [31:0] rd, input int n,
                          input string tag);
        step();
        req_read = !wr; req_write = wr; req_addr = a; req_mbe = m; req_wdata = wd;
        pipe_en = 1'b0;
        sb.push_back('{op_write: wr, addr: a, mbe: m, wdata: wd});
        #1;
        chk({tag, "_stall_c0"}, 64'(stall), 64'd1);
        chk({tag, "_noreq_c0"}, 64'(dmem_read | dmem_write), 64'd0);
        for (int i = 1; i <= n; i++) begin
            step();
            if (i == n) begin
                dmem_resp = 1'b1;
                dmem_rdata = wr ? 32'h5A5A_5A5A : rd;
            end
            #1;
            chk({tag, "_stall_busy"}, 64'(stall), 64'd1);
            chk({tag, "_req_busy"}, 64'(wr ? dmem_write : dmem_read), 64'd1);
        end
        if (!wr) model_rdata = rd;
        step();
        dmem_resp = 1'b0; dmem_rdata = '0;
        #1;
        chk({tag, "_stall_done"}, 64'(stall), 64'd0);
        chk({tag, "_req_done"}, 64'(dmem_read | dmem_write), 64'd0);
        chk({tag, "_rdata"}, 64'(rdata_out), 64'(model_rdata));
    endtask

    // DONE with pipe_en=1: pipeline advances, next instruction is non-memory.
    task automatic advance();
        step();
        req_read = 1'b0; req_write = 1'b0; pipe_en = 1'b1;
        #1;
        chk("adv_stall", 64'(stall), 64'd0);
    endtask

    initial begin
        rst = 1'b0; req_read = 1'b0; req_write = 1'b0; req_addr = '0; req_mbe = '0;
        req_wdata = '0; pipe_en = 1'b0; dmem_resp = 1'b0; dmem_rdata = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_stall", 64'(stall), 64'd0);
        chk("rst_rd", 64'(dmem_read), 64'd0);
        chk("rst_wr", 64'(dmem_write), 64'd0);
        chk("rst_addr", 64'(dmem_address), 64'd0);
        chk("rst_rdata", 64'(rdata_out), 64'd0);
        chk("rst_perf", 64'(perf_loads | perf_stores | perf_stall_cyc), 64'd0);
        rst = 1'b1;

        // Load, response after 2 cycles.
        access(1'b0, 32'h0000_1004, 4'hF, 32'h0, 32'hDEAD_BEEF, 2, "load1");
        // Stay in DONE with the load still presented: no re-issue, no stall.
        for (int i = 0; i < 4; i++) begin
            step();
            #1;
            chk("hold_stall", 64'(stall), 64'd0);
            chk("hold_noreq", 64'(dmem_read), 64'd0);
        end
        advance();
        step();
        pipe_en = 1'b0;
        #1;
        chk("idle_nomem_stall", 64'(stall), 64'd0);

        // Store leaves rdata_out alone.
        access(1'b1, 32'h0000_2000, 4'h2, 32'h0000_AB00, 32'h0, 3, "store1");
`ifdef DMEM_PERF_EN
        chk("perf_loads1", 64'(perf_loads), 64'd1);
        chk("perf_stores1", 64'(perf_stores), 64'd1);
`else
        chk("perf_tied0", 64'(perf_loads | perf_stores | perf_stall_cyc), 64'd0);
`endif
        advance();

        // Back-to-back load then store.
        access(1'b0, 32'h0000_3000, 4'hF, 32'h0, 32'h0BAD_F00D, 1, "b2b_ld");
        advance();
        access(1'b1, 32'h0000_3008, 4'hC, 32'h1234_0000, 32'h0, 1, "b2b_st");
        advance();

        // Reset while BUSY abandons the request; a late response is ignored.
        step();
        req_read = 1'b1; req_addr = 32'h0000_4000; req_mbe = 4'hF; req_wdata = '0;
        pipe_en = 1'b0;
        sb.push_back('{op_write: 1'b0, addr: 32'h0000_4000, mbe: 4'hF, wdata: 32'h0});
        step();
        #1;
        chk("rstb_req", 64'(dmem_read), 64'd1);
        step();
        rst = 1'b0;
        step();
        rst = 1'b1; req_read = 1'b0;
        model_rdata = '0;
        #1;
        chk("rstb_drop", 64'(dmem_read), 64'd0);
        chk("rstb_addr", 64'(dmem_address), 64'd0);
        chk("rstb_rdata", 64'(rdata_out), 64'd0);
        step();
        dmem_resp = 1'b1; dmem_rdata = 32'h0000_0BAD;
        step();
        dmem_resp = 1'b0; dmem_rdata = '0;
        #1;
        chk("late_resp_rdata", 64'(rdata_out), 64'd0);
        chk("late_resp_stall", 64'(stall), 64'd0);
        chk("late_resp_req", 64'(dmem_read | dmem_write), 64'd0);

        // Spurious response in IDLE.
        step();
        dmem_resp = 1'b1; dmem_rdata = 32'h0000_0077;
        #1;
        chk("spur_stall", 64'(stall), 64'd0);
        step();
        dmem_resp = 1'b0; dmem_rdata = '0;
        #1;
        chk("spur_rdata", 64'(rdata_out), 64'(model_rdata));
        chk("spur_req", 64'(dmem_read | dmem_write), 64'd0);
        chk("spur_addr", 64'(dmem_address), 64'd0);

        // Long load: 20 stall cycles since the last reset.
        access(1'b0, 32'h0000_5000, 4'hF, 32'h0, 32'h1111_2222, 19, "long_ld");
`ifdef DMEM_PERF_EN
        chk("perf_stall_sat", 64'(perf_stall_cyc), 64'hF);
        chk("perf_loads2", 64'(perf_loads), 64'd1);
        chk("perf_stores2", 64'(perf_stores), 64'd0);
`else
        chk("perf_tied0_end", 64'(perf_loads | perf_stores | perf_stall_cyc), 64'd0);
`endif
        advance();
        step();
        step();
        chk("sb_drained", 64'(sb.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
